// File: rtl/fft32_stage1_loader.sv
`default_nettype none
// ============================================================================
// Module   : fft32_stage1_loader
// Purpose  : Front end of the 32-point FFT datapath. Collects 32 complex
//            samples serially (valid/ready), stores sample n at buffer slot
//            bitrev5(n), runs the radix-2 stage-1 butterflies (W0 = 1, so
//            add/subtract only) and presents the 32 results as one registered
//            parallel frame, held until the downstream stage accepts it.
// Ports    : CLK           - clock
//            RST           - asynchronous active-low reset
//            i_data        - packed complex sample, real [15:8], imag [7:0]
//            i_valid       - i_data valid this cycle
//            o_ready       - sample can be accepted this cycle (LOAD only)
//            o_b0..o_b31   - butterfly outputs, same packing as i_data
//            o_valid       - o_b* hold a complete frame
//            i_ready       - downstream accepts the held frame
//            o_sat         - at least one component of this frame clamped
// Options  : FFT_STAGE1_SCALE_EN - when defined, each 9-bit sum/difference is
//            arithmetic-shifted right by one instead of saturated; o_sat is 0.
// Revision : 1.0 - initial release
// ============================================================================
module fft32_stage1_loader #(
  parameter int p_inputBits  = 16,
  parameter int p_realBits   = 8,
  parameter int p_outputBits = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [p_inputBits-1:0]  i_data,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [p_outputBits-1:0] o_b0,
  output logic [p_outputBits-1:0] o_b1,
  output logic [p_outputBits-1:0] o_b2,
  output logic [p_outputBits-1:0] o_b3,
  output logic [p_outputBits-1:0] o_b4,
  output logic [p_outputBits-1:0] o_b5,
  output logic [p_outputBits-1:0] o_b6,
  output logic [p_outputBits-1:0] o_b7,
  output logic [p_outputBits-1:0] o_b8,
  output logic [p_outputBits-1:0] o_b9,
  output logic [p_outputBits-1:0] o_b10,
  output logic [p_outputBits-1:0] o_b11,
  output logic [p_outputBits-1:0] o_b12,
  output logic [p_outputBits-1:0] o_b13,
  output logic [p_outputBits-1:0] o_b14,
  output logic [p_outputBits-1:0] o_b15,
  output logic [p_outputBits-1:0] o_b16,
  output logic [p_outputBits-1:0] o_b17,
  output logic [p_outputBits-1:0] o_b18,
  output logic [p_outputBits-1:0] o_b19,
  output logic [p_outputBits-1:0] o_b20,
  output logic [p_outputBits-1:0] o_b21,
  output logic [p_outputBits-1:0] o_b22,
  output logic [p_outputBits-1:0] o_b23,
  output logic [p_outputBits-1:0] o_b24,
  output logic [p_outputBits-1:0] o_b25,
  output logic [p_outputBits-1:0] o_b26,
  output logic [p_outputBits-1:0] o_b27,
  output logic [p_outputBits-1:0] o_b28,
  output logic [p_outputBits-1:0] o_b29,
  output logic [p_outputBits-1:0] o_b30,
  output logic [p_outputBits-1:0] o_b31,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_sat
);

  localparam int c_points   = 32;
  localparam int c_pairs    = 16;
  localparam int c_cntBits  = 5;
  localparam int c_extBits  = p_realBits + 1;
  localparam logic [c_cntBits-1:0] c_lastIdx = 5'd31;

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_stateNext;
  logic [c_cntBits-1:0]    r_cnt;
  logic [p_inputBits-1:0]  r_buf [c_points];
  logic [p_outputBits-1:0] r_out [c_points];
  logic                    r_valid;
  logic                    r_sat;

  logic                    w_ready;
  logic                    w_load;
  logic                    w_compute;
  logic                    w_release;
  logic [p_outputBits-1:0] w_res   [c_points];
  logic [c_points-1:0]     w_clamp;

  // Bit-reverse a 5-bit sample index.
  function automatic logic [c_cntBits-1:0] f_bitrev(input logic [c_cntBits-1:0] n);
    logic [c_cntBits-1:0] r;
    for (int i = 0; i < c_cntBits; i++) begin
      r[i] = n[c_cntBits-1-i];
    end
    return r;
  endfunction

  // One component of a butterfly. Returns {clamped, result}.
  function automatic logic [p_realBits:0] f_bfly(
    input logic [p_realBits-1:0] a,
    input logic [p_realBits-1:0] b,
    input logic                  sub
  );
    logic [c_extBits-1:0]  ea;
    logic [c_extBits-1:0]  eb;
    logic [c_extBits-1:0]  r;
    logic [p_realBits-1:0] q;
    logic                  clamp;
    ea = {a[p_realBits-1], a};
    eb = {b[p_realBits-1], b};
    r  = sub ? (ea - eb) : (ea + eb);
`ifdef FFT_STAGE1_SCALE_EN
    // 9-bit result halved always fits in 8 bits.
    q     = r[c_extBits-1:1];
    clamp = 1'b0;
`else
    // Overflow of the 8-bit range shows up as the two top bits differing;
    // the 9-bit sign bit tells which rail to clamp to.
    clamp = r[p_realBits] ^ r[p_realBits-1];
    if (clamp) begin
      q = {r[p_realBits], {(p_realBits-1){~r[p_realBits]}}};
    end else begin
      q = r[p_realBits-1:0];
    end
`endif
    return {clamp, q};
  endfunction

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_ready     = 1'b0;
    w_load      = 1'b0;
    w_compute   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_ready = 1'b1;
        if (i_valid) begin
          w_load = 1'b1;
          if (r_cnt == c_lastIdx) begin
            w_stateNext = S_COMPUTE;
          end
        end
      end
      S_COMPUTE: begin
        w_compute   = 1'b1;
        w_stateNext = S_HOLD;
      end
      S_HOLD: begin
        if (i_ready) begin
          w_release   = 1'b1;
          w_stateNext = S_LOAD;
        end
      end
      default: begin
        w_stateNext = S_LOAD;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Sample buffer (contents irrelevant after reset, so no reset term)
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (w_load) begin
      r_buf[f_bitrev(r_cnt)] <= i_data;
    end
  end

  // --------------------------------------------------------------------------
  // Stage-1 butterflies on adjacent bit-reversed slots
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < c_pairs; k++) begin : g_bfly
    logic [p_realBits:0] w_sumRe;
    logic [p_realBits:0] w_sumIm;
    logic [p_realBits:0] w_difRe;
    logic [p_realBits:0] w_difIm;

    assign w_sumRe = f_bfly(r_buf[2*k][2*p_realBits-1:p_realBits],
                            r_buf[2*k+1][2*p_realBits-1:p_realBits], 1'b0);
    assign w_sumIm = f_bfly(r_buf[2*k][p_realBits-1:0],
                            r_buf[2*k+1][p_realBits-1:0], 1'b0);
    assign w_difRe = f_bfly(r_buf[2*k][2*p_realBits-1:p_realBits],
                            r_buf[2*k+1][2*p_realBits-1:p_realBits], 1'b1);
    assign w_difIm = f_bfly(r_buf[2*k][p_realBits-1:0],
                            r_buf[2*k+1][p_realBits-1:0], 1'b1);

    assign w_res[2*k]     = {w_sumRe[p_realBits-1:0], w_sumIm[p_realBits-1:0]};
    assign w_res[2*k+1]   = {w_difRe[p_realBits-1:0], w_difIm[p_realBits-1:0]};
    assign w_clamp[2*k]   = w_sumRe[p_realBits] | w_sumIm[p_realBits];
    assign w_clamp[2*k+1] = w_difRe[p_realBits] | w_difIm[p_realBits];
  end

  // --------------------------------------------------------------------------
  // Counter, output frame and flags
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_sat   <= 1'b0;
      for (int i = 0; i < c_points; i++) begin
        r_out[i] <= '0;
      end
    end else begin
      // Wraps from 31 to 0 on the last accepted sample.
      if (w_load) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_compute) begin
        r_valid <= 1'b1;
        r_sat   <= |w_clamp;
        for (int i = 0; i < c_points; i++) begin
          r_out[i] <= w_res[i];
        end
      end else if (w_release) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_ready = w_ready;
  assign o_valid = r_valid;
  assign o_sat   = r_sat;

  assign o_b0  = r_out[0];
  assign o_b1  = r_out[1];
  assign o_b2  = r_out[2];
  assign o_b3  = r_out[3];
  assign o_b4  = r_out[4];
  assign o_b5  = r_out[5];
  assign o_b6  = r_out[6];
  assign o_b7  = r_out[7];
  assign o_b8  = r_out[8];
  assign o_b9  = r_out[9];
  assign o_b10 = r_out[10];
  assign o_b11 = r_out[11];
  assign o_b12 = r_out[12];
  assign o_b13 = r_out[13];
  assign o_b14 = r_out[14];
  assign o_b15 = r_out[15];
  assign o_b16 = r_out[16];
  assign o_b17 = r_out[17];
  assign o_b18 = r_out[18];
  assign o_b19 = r_out[19];
  assign o_b20 = r_out[20];
  assign o_b21 = r_out[21];
  assign o_b22 = r_out[22];
  assign o_b23 = r_out[23];
  assign o_b24 = r_out[24];
  assign o_b25 = r_out[25];
  assign o_b26 = r_out[26];
  assign o_b27 = r_out[27];
  assign o_b28 = r_out[28];
  assign o_b29 = r_out[29];
  assign o_b30 = r_out[30];
  assign o_b31 = r_out[31];

endmodule
`default_nettype wire

// File: tb/tb_fft32_stage1_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft32_stage1_loader
// Purpose  : Self-checking bench for fft32_stage1_loader. A frame-level
//            reference model (bit-reversed indexing plus integer add/sub with
//            clamp or halving) predicts every output frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft32_stage1_loader;

  logic        CLK;
  logic        RST;
  logic [15:0] i_data;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] ob [32];
  logic        o_valid;
  logic        i_ready;
  logic        o_sat;

  int n_checks;
  int n_fail;

  logic [15:0] frame [32];
  logic [15:0] exp_b [32];
  logic        exp_sat;

  fft32_stage1_loader dut (
    .CLK(CLK), .RST(RST), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_b0(ob[0]),   .o_b1(ob[1]),   .o_b2(ob[2]),   .o_b3(ob[3]),
    .o_b4(ob[4]),   .o_b5(ob[5]),   .o_b6(ob[6]),   .o_b7(ob[7]),
    .o_b8(ob[8]),   .o_b9(ob[9]),   .o_b10(ob[10]), .o_b11(ob[11]),
    .o_b12(ob[12]), .o_b13(ob[13]), .o_b14(ob[14]), .o_b15(ob[15]),
    .o_b16(ob[16]), .o_b17(ob[17]), .o_b18(ob[18]), .o_b19(ob[19]),
    .o_b20(ob[20]), .o_b21(ob[21]), .o_b22(ob[22]), .o_b23(ob[23]),
    .o_b24(ob[24]), .o_b25(ob[25]), .o_b26(ob[26]), .o_b27(ob[27]),
    .o_b28(ob[28]), .o_b29(ob[29]), .o_b30(ob[30]), .o_b31(ob[31]),
    .o_valid(o_valid), .i_ready(i_ready), .o_sat(o_sat)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  function automatic int bitrev5(input int n);
    int r;
    int v;
    r = 0;
    v = n;
    for (int i = 0; i < 5; i++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  function automatic int s8(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [7:0] comp(input int x, input int y, input bit sub, output bit clamped);
    int r;
    r = sub ? (x - y) : (x + y);
    clamped = 1'b0;
`ifdef FFT_STAGE1_SCALE_EN
    r = r >>> 1;
`else
    if (r > 127) begin r = 127; clamped = 1'b1; end
    if (r < -128) begin r = -128; clamped = 1'b1; end
`endif
    return r[7:0];
  endfunction

  // Buffer slot j holds sample bitrev5(j); butterflies pair slots 2k, 2k+1.
  task automatic build_expected();
    logic [15:0] a;
    logic [15:0] b;
    bit c0, c1, c2, c3;
    exp_sat = 1'b0;
    for (int k = 0; k < 16; k++) begin
      a = frame[bitrev5(2 * k)];
      b = frame[bitrev5(2 * k + 1)];
      exp_b[2*k]   = {comp(s8(a[15:8]), s8(b[15:8]), 1'b0, c0), comp(s8(a[7:0]), s8(b[7:0]), 1'b0, c1)};
      exp_b[2*k+1] = {comp(s8(a[15:8]), s8(b[15:8]), 1'b1, c2), comp(s8(a[7:0]), s8(b[7:0]), 1'b1, c3)};
      if (c0 || c1 || c2 || c3) exp_sat = 1'b1;
    end
  endtask

  // ---------------- frame driver ----------------
  // Sends frame[0..31]; optionally with random idle cycles. Checks latency
  // and the resulting frame against the model. Ends at the negedge after
  // o_valid is expected to have risen.
  task automatic run_frame(input bit gaps);
    build_expected();
    for (int n = 0; n < 32; n++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          i_valid = 1'b0;
          i_data  = 16'($urandom);
          @(negedge CLK);
        end
      end
      i_valid = 1'b1;
      i_data  = frame[n];
      n_checks++;
      if (o_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL load_ready sample %0d: got %b expected 1", n, o_ready);
      end
      @(negedge CLK);
    end
    i_valid = 1'b0;
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL compute_cycle: o_valid=%b o_ready=%b expected 0/0", o_valid, o_ready);
    end
    @(negedge CLK);
    n_checks++;
    if (o_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL latency: o_valid=%b expected 1", o_valid);
    end
    for (int j = 0; j < 32; j++) begin
      n_checks++;
      if (ob[j] !== exp_b[j]) begin
        n_fail++;
        $display("FAIL o_b%0d: got %h expected %h", j, ob[j], exp_b[j]);
      end
    end
    n_checks++;
    if (o_sat !== exp_sat) begin
      n_fail++;
      $display("FAIL o_sat: got %b expected %b", o_sat, exp_sat);
    end
  endtask

  // Holds the frame for `cycles` with i_ready=0 and i_valid=1, then releases.
  task automatic release_frame(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      i_ready = 1'b0;
      i_valid = 1'b1;
      i_data  = 16'($urandom);
      @(negedge CLK);
      n_checks++;
      if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_sat !== exp_sat) begin
        n_fail++;
        $display("FAIL hold_flags cycle %0d: ready=%b valid=%b sat=%b expected 0/1/%b", c, o_ready, o_valid, o_sat, exp_sat);
      end
      for (int j = 0; j < 32; j++) begin
        if (ob[j] !== exp_b[j]) begin
          n_fail++;
          $display("FAIL hold_stable o_b%0d: got %h expected %h", j, ob[j], exp_b[j]);
        end
      end
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge CLK);
    i_ready = 1'b0;
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release: o_valid=%b o_ready=%b expected 0/1", o_valid, o_ready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_data = '0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (o_valid !== 1'b0 || o_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: o_valid=%b o_sat=%b expected 0/0", o_valid, o_sat);
    end
    for (int j = 0; j < 32; j++) begin
      n_checks++;
      if (ob[j] !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_o_b%0d: got %h expected 0000", j, ob[j]);
      end
    end
    RST = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 1", o_ready);
    end
  endtask

  task automatic test_impulse();
    for (int j = 0; j < 32; j++) frame[j] = 16'h0000;
    frame[0] = 16'h0100;
    i_ready = 1'b1;
    run_frame(1'b0);
    n_checks++;
    if (ob[0] !== 16'h0100 || ob[1] !== 16'h0100 || ob[2] !== 16'h0000 || o_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL impulse: b0=%h b1=%h b2=%h sat=%b expected 0100/0100/0000/0", ob[0], ob[1], ob[2], o_sat);
    end
    release_frame(0);
  endtask

  task automatic test_pairs();
    for (int j = 0; j < 32; j++) frame[j] = 16'h0000;
    frame[16] = 16'h0200;
    frame[8]  = 16'h0003;
    run_frame(1'b0);
    n_checks++;
    if (ob[0] !== 16'h0200 || ob[1] !== 16'hFE00 || ob[2] !== 16'h0003 || ob[3] !== 16'h0003) begin
      n_fail++;
      $display("FAIL pairs: b0=%h b1=%h b2=%h b3=%h expected 0200/FE00/0003/0003", ob[0], ob[1], ob[2], ob[3]);
    end
    release_frame(0);
  endtask

  task automatic test_saturation();
    for (int j = 0; j < 32; j++) frame[j] = 16'h0000;
    frame[0]  = 16'h7f00;
    frame[16] = 16'h0100;
    run_frame(1'b0);
    n_checks++;
`ifdef FFT_STAGE1_SCALE_EN
    if (ob[0] !== 16'h4000 || ob[1] !== 16'h3f00 || o_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL scale: b0=%h b1=%h sat=%b expected 4000/3f00/0", ob[0], ob[1], o_sat);
    end
`else
    if (ob[0] !== 16'h7f00 || ob[1] !== 16'h7e00 || o_sat !== 1'b1) begin
      n_fail++;
      $display("FAIL saturate: b0=%h b1=%h sat=%b expected 7f00/7e00/1", ob[0], ob[1], o_sat);
    end
`endif
    release_frame(0);
    // Next frame has no clamp: o_sat must be recomputed, not sticky.
    for (int j = 0; j < 32; j++) frame[j] = 16'h0101;
    run_frame(1'b0);
    release_frame(0);
  endtask

  task automatic test_hold();
    for (int j = 0; j < 32; j++) frame[j] = 16'($urandom);
    i_ready = 1'b0;
    run_frame(1'b0);
    release_frame(10);
    for (int j = 0; j < 32; j++) frame[j] = 16'($urandom);
    run_frame(1'b0);
    release_frame(2);
  endtask

  task automatic test_reset_midload();
    for (int n = 0; n < 20; n++) begin
      i_valid = 1'b1;
      i_data  = 16'($urandom);
      @(negedge CLK);
    end
    i_valid = 1'b0;
    RST = 1'b0;
    #1;
    n_checks++;
    if (o_valid !== 1'b0 || o_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: o_valid=%b o_sat=%b expected 0/0", o_valid, o_sat);
    end
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    for (int j = 0; j < 32; j++) frame[j] = 16'h8080;
    run_frame(1'b0);
    n_checks++;
`ifdef FFT_STAGE1_SCALE_EN
    if (ob[0] !== 16'h8080 || ob[31] !== 16'h0000 || o_sat !== 1'b0) begin
`else
    if (ob[0] !== 16'h8080 || ob[31] !== 16'h0000 || o_sat !== 1'b1) begin
`endif
      n_fail++;
      $display("FAIL midload_reset: b0=%h b31=%h sat=%b", ob[0], ob[31], o_sat);
    end
    release_frame(1);
  endtask

  task automatic test_random();
    for (int f = 0; f < 5; f++) begin
      for (int j = 0; j < 32; j++) frame[j] = 16'($urandom);
      run_frame(1'b1);
      release_frame(int'($urandom_range(0, 4)));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_impulse();
    test_pairs();
    test_saturation();
    test_hold();
    test_reset_midload();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
